kbd_scan_ctrl: RTL

Controller downstream of the PS/2 byte receiver (8-bit data bus plus data-valid level in the ps2_clk domain). It synchronises the receiver's valid level into the system clock and sequences multi-byte scan-code set 2 messages (E0/F0 prefixes) through an FSM. It maintains held-key state for the two Bomberman players and emits one decoded key event per completed message to the game logic.

---
 rtl/kbd_pkg.sv | 63 ++++++
 rtl/kbd_sync_edge.sv | 35 +++
 rtl/kbd_scan_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared constants, state encoding and scan-code key map for the PS/2 keyboard controller.
package kbd_pkg;

  localparam logic [7:0] CODE_E0    = 8'hE0;
  localparam logic [7:0] CODE_F0    = 8'hF0;
  localparam logic [7:0] CODE_OVR_0 = 8'h00;
  localparam logic [7:0] CODE_OVR_1 = 8'hFF;

  localparam int unsigned KEY_W = 5;

  localparam logic [2:0] KEY_UP    = 3'd0;
  localparam logic [2:0] KEY_LEFT  = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_RIGHT = 3'd3;
  localparam logic [2:0] KEY_BOMB  = 3'd4;

  localparam logic [7:0] P1_UP    = 8'h1D;
  localparam logic [7:0] P1_LEFT  = 8'h1C;
  localparam logic [7:0] P1_DOWN  = 8'h1B;
  localparam logic [7:0] P1_RIGHT = 8'h23;
  localparam logic [7:0] P1_BOMB  = 8'h29;

  localparam logic [7:0] P2_UP    = 8'h75;
  localparam logic [7:0] P2_LEFT  = 8'h6B;
  localparam logic [7:0] P2_DOWN  = 8'h72;
  localparam logic [7:0] P2_RIGHT = 8'h74;
  localparam logic [7:0] P2_BOMB  = 8'h5A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_E0   = 2'd1,
    S_F0   = 2'd2,
    S_E0F0 = 2'd3
  } kbd_state_e;

  typedef struct packed {
    logic       hit;
    logic       p2;
    logic [2:0] idx;
  } key_hit_t;

  // Extended flag is part of the match: keypad codes without E0 stay unmapped.
  function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
    key_hit_t r;
    r = '{hit: 1'b1, p2: 1'b0, idx: KEY_UP};
    if (!ext && code == P1_UP)         r.idx = KEY_UP;
    else if (!ext && code == P1_LEFT)  r.idx = KEY_LEFT;
    else if (!ext && code == P1_DOWN)  r.idx = KEY_DOWN;
    else if (!ext && code == P1_RIGHT) r.idx = KEY_RIGHT;
    else if (!ext && code == P1_BOMB)  r.idx = KEY_BOMB;
    else begin
      r.p2 = 1'b1;
      if (ext && code == P2_UP)          r.idx = KEY_UP;
      else if (ext && code == P2_LEFT)   r.idx = KEY_LEFT;
      else if (ext && code == P2_DOWN)   r.idx = KEY_DOWN;
      else if (ext && code == P2_RIGHT)  r.idx = KEY_RIGHT;
      else if (!ext && code == P2_BOMB)  r.idx = KEY_BOMB;
      else                               r.hit = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/kbd_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level plus a registered rising-edge pulse.
module kbd_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic pulse
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[STAGES-2:0], async_in};
    prev_d  = sync_q[STAGES-1];
    pulse_d = sync_q[STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/kbd_scan_ctrl.sv
// Scan-code set 2 message sequencer: tracks E0/F0 prefixes, held keys for two players, events and errors.
module kbd_scan_ctrl
  import kbd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_valid,
  input  logic             clr_keys,
  output logic [KEY_W-1:0] p1_keys,
  output logic [KEY_W-1:0] p2_keys,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic byte_stb;

  kbd_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (kbd_valid),
    .pulse    (byte_stb)
  );

  kbd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic             evt_valid_q, evt_valid_d;
  logic [7:0]       code_q, code_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic             err_q, err_d;
  logic             cur_ext_c, cur_brk_c;
  key_hit_t         hit_c;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    evt_valid_d = 1'b0;
    code_d      = code_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    err_d       = 1'b0;
    cur_ext_c   = (state_q == S_E0) || (state_q == S_E0F0);
    cur_brk_c   = (state_q == S_F0) || (state_q == S_E0F0);
    hit_c       = key_lookup(kbd_data, cur_ext_c);

    if (byte_stb) begin
      cnt_d = '0;
      if (kbd_data == CODE_OVR_0 || kbd_data == CODE_OVR_1) begin
        p1_d    = '0;
        p2_d    = '0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else if (kbd_data == CODE_E0) begin
        err_d   = (state_q != S_IDLE);
        state_d = S_E0;
      end else if (kbd_data == CODE_F0) begin
        if (state_q == S_IDLE) begin
          state_d = S_F0;
        end else if (state_q == S_E0) begin
          state_d = S_E0F0;
        end else begin
          err_d   = 1'b1;
          state_d = S_F0;
        end
      end else begin
        evt_valid_d = 1'b1;
        code_d      = kbd_data;
        ext_d       = cur_ext_c;
        brk_d       = cur_brk_c;
        state_d     = S_IDLE;
        if (hit_c.hit) begin
          if (hit_c.p2) p2_d[hit_c.idx] = ~cur_brk_c;
          else          p1_d[hit_c.idx] = ~cur_brk_c;
        end
      end
    end else if (state_q != S_IDLE) begin
      // Abandon a dangling prefix if the next byte never arrives.
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        cnt_d   = '0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end

    if (clr_keys) begin
      p1_d = '0;
      p2_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      evt_valid_q <= 1'b0;
      code_q      <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      evt_valid_q <= evt_valid_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      err_q       <= err_d;
    end
  end

  assign p1_keys   = p1_q;
  assign p2_keys   = p2_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = code_q;
  assign evt_ext   = ext_q;
  assign evt_break = brk_q;
  assign err       = err_q;

endmodule
